// File: rtl/ultra_ranger_mc.sv
// Round-robin multi-channel ultrasonic ranger: triggers each sensor, times its echo and
// converts the width to centimetres with a prescaler, flagging per-channel proximity.
module ultra_ranger_mc #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int N_CH       = 2,
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 30000,
    parameter int GAP_US     = 60000,
    parameter int DIST_W     = 9,
    parameter int THRESH_CM  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_CH-1:0]   echo,
    output logic [N_CH-1:0]   trig,
    output logic              busy,
    output logic              done,
    output logic [2:0]        ch_idx,
    output logic [DIST_W-1:0] dist_cm,
    output logic              tout,
    output logic [N_CH-1:0]   near
);

    localparam int          US          = CLK_HZ / 1_000_000;
    localparam logic [31:0] CYC_PER_CM  = 32'(58 * US);
    localparam logic [31:0] TRIG_CYC    = 32'(TRIG_US * US);
    localparam logic [31:0] TIMEOUT_CYC = 32'(TIMEOUT_US * US);
    localparam logic [31:0] GAP_CYC     = 32'(GAP_US * US);
    localparam logic [DIST_W-1:0] DIST_MAX = '1;
    localparam logic [2:0]  LAST_CH     = 3'(N_CH - 1);

    typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT_HI, S_MEASURE, S_GAP} state_t;

    state_t            state;
    logic [2:0]        ch;
    logic [31:0]       cnt;
    logic [31:0]       presc;
    logic [DIST_W-1:0] cm;
    logic [N_CH-1:0]   echo_m;
    logic [N_CH-1:0]   echo_s;
    logic              echo_cur;

    function automatic logic [N_CH-1:0] onehot(input logic [2:0] c);
        logic [N_CH-1:0] r;
        r = '0;
        for (int i = 0; i < N_CH; i++)
            if (3'(i) == c) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [N_CH-1:0] set_near(input logic [N_CH-1:0] cur,
                                                 input logic [2:0] c, input logic v);
        logic [N_CH-1:0] r;
        r = cur;
        for (int i = 0; i < N_CH; i++)
            if (3'(i) == c) r[i] = v;
        return r;
    endfunction

    always_comb begin
        echo_cur = 1'b0;
        for (int i = 0; i < N_CH; i++)
            if (3'(i) == ch) echo_cur = echo_s[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            ch      <= '0;
            cnt     <= '0;
            presc   <= '0;
            cm      <= '0;
            echo_m  <= '0;
            echo_s  <= '0;
            trig    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ch_idx  <= '0;
            dist_cm <= '0;
            tout    <= 1'b0;
            near    <= '0;
        end else begin
            echo_m <= echo;
            echo_s <= echo_m;
            done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ch    <= '0;
                        cnt   <= '0;
                        trig  <= onehot(3'd0);
                        busy  <= 1'b1;
                        state <= S_TRIG;
                    end
                end
                S_TRIG: begin
                    if (cnt == TRIG_CYC - 32'd1) begin
                        trig  <= '0;
                        cnt   <= '0;
                        state <= S_WAIT_HI;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_WAIT_HI: begin
                    // The detection cycle already counts as one high cycle.
                    if (echo_cur) begin
                        presc <= 32'd1;
                        cm    <= '0;
                        cnt   <= 32'd1;
                        state <= S_MEASURE;
                    end else if (cnt >= TIMEOUT_CYC - 32'd1) begin
                        done    <= 1'b1;
                        ch_idx  <= ch;
                        dist_cm <= DIST_MAX;
                        tout    <= 1'b1;
                        near    <= set_near(near, ch, 1'b0);
                        cnt     <= '0;
                        state   <= S_GAP;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_MEASURE: begin
                    if (!echo_cur) begin
                        done    <= 1'b1;
                        ch_idx  <= ch;
                        dist_cm <= cm;
                        tout    <= 1'b0;
                        near    <= set_near(near, ch, (32'(cm) < 32'(THRESH_CM)));
                        cnt     <= '0;
                        state   <= S_GAP;
                    end else if (cnt >= TIMEOUT_CYC - 32'd1) begin
                        done    <= 1'b1;
                        ch_idx  <= ch;
                        dist_cm <= DIST_MAX;
                        tout    <= 1'b1;
                        near    <= set_near(near, ch, 1'b0);
                        cnt     <= '0;
                        state   <= S_GAP;
                    end else begin
                        cnt <= cnt + 32'd1;
                        if (presc == CYC_PER_CM - 32'd1) begin
                            presc <= '0;
                            if (cm != DIST_MAX) cm <= cm + DIST_W'(1);
                        end else begin
                            presc <= presc + 32'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_CYC - 32'd1) begin
                        cnt <= '0;
                        if (ch == LAST_CH) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            ch    <= ch + 3'd1;
                            trig  <= onehot(ch + 3'd1);
                            state <= S_TRIG;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ultra_ranger_mc.sv
// Directed bench for ultra_ranger_mc at a 1 MHz clock (58 cycles per cm).
module tb_ultra_ranger_mc;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] echo;
    logic [1:0] trig;
    logic       busy, done, tout;
    logic [2:0] ch_idx;
    logic [8:0] dist_cm;
    logic [1:0] near;

    logic       sat_start;
    logic [1:0] sat_echo;
    logic [1:0] sat_trig;
    logic       sat_busy, sat_done, sat_tout;
    logic [2:0] sat_ch_idx;
    logic [3:0] sat_dist;
    logic [1:0] sat_near;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ultra_ranger_mc #(.CLK_HZ(1_000_000), .N_CH(2), .TRIG_US(10), .TIMEOUT_US(2000),
                      .GAP_US(100), .DIST_W(9), .THRESH_CM(20)) dut (
        .clk(clk), .rst(rst), .start(start), .echo(echo), .trig(trig), .busy(busy),
        .done(done), .ch_idx(ch_idx), .dist_cm(dist_cm), .tout(tout), .near(near));

    ultra_ranger_mc #(.CLK_HZ(1_000_000), .N_CH(2), .TRIG_US(10), .TIMEOUT_US(2000),
                      .GAP_US(100), .DIST_W(4), .THRESH_CM(20)) dut_sat (
        .clk(clk), .rst(rst), .start(sat_start), .echo(sat_echo), .trig(sat_trig),
        .busy(sat_busy), .done(sat_done), .ch_idx(sat_ch_idx), .dist_cm(sat_dist),
        .tout(sat_tout), .near(sat_near));

    task automatic wait_trig(input int c, input logic lvl, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (trig[c] === lvl) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (done === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic pulse_echo(input int c, input int n);
        echo[c] = 1'b1;
        repeat (n) @(negedge clk);
        echo[c] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; echo = 2'b00; sat_start = 1'b0; sat_echo = 2'b00;
        repeat (3) @(negedge clk);
        tests++; if (trig !== 2'b00) begin fails++; $display("FAIL reset_trig got %b want 00", trig); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++; if (ch_idx !== 3'd0) begin fails++; $display("FAIL reset_ch_idx got %0d want 0", ch_idx); end
        tests++; if (dist_cm !== 9'd0) begin fails++; $display("FAIL reset_dist got %0d want 0", dist_cm); end
        tests++; if (tout !== 1'b0) begin fails++; $display("FAIL reset_tout got %b want 0", tout); end
        tests++; if (near !== 2'b00) begin fails++; $display("FAIL reset_near got %b want 00", near); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_trig_width;
        int n;
        bit saw1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL tw_busy got %b want 1", busy); end
        tests++; if (trig !== 2'b01) begin fails++; $display("FAIL tw_trig got %b want 01", trig); end
        n = 0; saw1 = 1'b0;
        for (int i = 0; i < 50 && trig[0] === 1'b1; i++) begin
            n++;
            if (trig[1] !== 1'b0) saw1 = 1'b1;
            @(negedge clk);
        end
        tests++; if (n != 10) begin fails++; $display("FAIL tw_width got %0d want 10", n); end
        tests++; if (saw1) begin fails++; $display("FAIL tw_trig1 got 1 want 0"); end
    endtask

    // ch0 stays in WAIT_HI after test_trig_width; 579 cycles is just short of 10 cm.
    task automatic test_partial_cm;
        bit ok;
        pulse_echo(0, 579);
        wait_done(ok);
        tests++; if (!ok) begin fails++; $display("FAIL pc_done got timeout want pulse"); end
        tests++; if (dist_cm !== 9'd9) begin fails++; $display("FAIL pc_dist got %0d want 9", dist_cm); end
        tests++; if (tout !== 1'b0) begin fails++; $display("FAIL pc_tout got %b want 0", tout); end
        tests++; if (ch_idx !== 3'd0) begin fails++; $display("FAIL pc_ch got %0d want 0", ch_idx); end
        tests++; if (near !== 2'b01) begin fails++; $display("FAIL pc_near got %b want 01", near); end
    endtask

    task automatic test_no_echo;
        bit ok;
        int n;
        wait_trig(1, 1'b1, ok);
        tests++; if (!ok) begin fails++; $display("FAIL ne_trig1 got none want rise"); end
        wait_trig(1, 1'b0, ok);
        n = 0;
        while (done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        tests++; if (n != 2000) begin fails++; $display("FAIL ne_latency got %0d want 2000", n); end
        tests++; if (tout !== 1'b1) begin fails++; $display("FAIL ne_tout got %b want 1", tout); end
        tests++; if (dist_cm !== 9'd511) begin fails++; $display("FAIL ne_dist got %0d want 511", dist_cm); end
        tests++; if (ch_idx !== 3'd1) begin fails++; $display("FAIL ne_ch got %0d want 1", ch_idx); end
        tests++; if (near !== 2'b01) begin fails++; $display("FAIL ne_near got %b want 01", near); end
        n = 0;
        while (busy === 1'b1 && n < 500) begin @(negedge clk); n++; end
        tests++; if (n != 100) begin fails++; $display("FAIL ne_gap got %0d want 100", n); end
    endtask

    task automatic test_busy_reject;
        int cyc, dones, nseq, stray;
        int seq [4];
        logic [1:0] prev;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        prev = 2'b00; cyc = 0; dones = 0; nseq = 0;
        while (dones < 2 && cyc < 6000) begin
            for (int c = 0; c < 2; c++)
                if (trig[c] === 1'b1 && prev[c] !== 1'b1) begin
                    if (nseq < 4) seq[nseq] = c;
                    nseq++;
                end
            prev = trig;
            if (done === 1'b1) dones++;
            if (dones < 2) begin @(negedge clk); cyc++; start = (cyc == 50); end
        end
        start = 1'b0;
        tests++; if (dones != 2) begin fails++; $display("FAIL br_dones got %0d want 2", dones); end
        tests++; if (nseq != 2) begin fails++; $display("FAIL br_ntrig got %0d want 2", nseq); end
        tests++; if (seq[0] != 0 || seq[1] != 1) begin fails++; $display("FAIL br_order got %0d,%0d want 0,1", seq[0], seq[1]); end
        stray = 0;
        for (int k = 1; k <= 99; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || trig !== 2'b00) stray++;
        end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL br_lastgap_busy got %b want 1", busy); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL br_exit_busy got %b want 0", busy); end
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (busy !== 1'b0 || trig !== 2'b00 || done !== 1'b0) stray++;
        end
        tests++; if (stray != 0) begin fails++; $display("FAIL br_stray got %0d want 0", stray); end
    endtask

    task automatic test_range;
        bit ok;
        int stray, n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_trig(0, 1'b0, ok);
        stray = 0;
        echo[1] = 1'b1;
        repeat (30) begin @(negedge clk); if (done !== 1'b0) stray++; end
        echo[1] = 1'b0;
        repeat (5) begin @(negedge clk); if (done !== 1'b0 || trig !== 2'b00) stray++; end
        tests++; if (stray != 0) begin fails++; $display("FAIL rg_other_ch got %0d want 0", stray); end
        pulse_echo(0, 580);
        wait_done(ok);
        tests++; if (!ok) begin fails++; $display("FAIL rg0_done got timeout want pulse"); end
        tests++; if (dist_cm !== 9'd10) begin fails++; $display("FAIL rg0_dist got %0d want 10", dist_cm); end
        tests++; if (tout !== 1'b0) begin fails++; $display("FAIL rg0_tout got %b want 0", tout); end
        tests++; if (ch_idx !== 3'd0) begin fails++; $display("FAIL rg0_ch got %0d want 0", ch_idx); end
        tests++; if (near !== 2'b01) begin fails++; $display("FAIL rg0_near got %b want 01", near); end
        wait_trig(1, 1'b1, ok);
        wait_trig(1, 1'b0, ok);
        pulse_echo(1, 1160);
        wait_done(ok);
        tests++; if (!ok) begin fails++; $display("FAIL rg1_done got timeout want pulse"); end
        tests++; if (dist_cm !== 9'd20) begin fails++; $display("FAIL rg1_dist got %0d want 20", dist_cm); end
        tests++; if (ch_idx !== 3'd1) begin fails++; $display("FAIL rg1_ch got %0d want 1", ch_idx); end
        tests++; if (near !== 2'b01) begin fails++; $display("FAIL rg1_near got %b want 01", near); end
        n = 0;
        while (busy === 1'b1 && n < 500) begin @(negedge clk); n++; end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rg_busy_end got %b want 0", busy); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_trig(0, 1'b0, ok);
        echo[0] = 1'b1;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        #1;
        tests++; if (trig !== 2'b00) begin fails++; $display("FAIL rm_trig got %b want 00", trig); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rm_busy got %b want 0", busy); end
        tests++; if (near !== 2'b00) begin fails++; $display("FAIL rm_near got %b want 00", near); end
        tests++; if (dist_cm !== 9'd0) begin fails++; $display("FAIL rm_dist got %0d want 0", dist_cm); end
        echo[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_trig(0, 1'b0, ok);
        pulse_echo(0, 1160);
        wait_done(ok);
        tests++; if (!ok) begin fails++; $display("FAIL rm0_done got timeout want pulse"); end
        tests++; if (dist_cm !== 9'd20) begin fails++; $display("FAIL rm0_dist got %0d want 20", dist_cm); end
        tests++; if (near !== 2'b00) begin fails++; $display("FAIL rm0_near got %b want 00", near); end
        wait_trig(1, 1'b1, ok);
        wait_trig(1, 1'b0, ok);
        pulse_echo(1, 290);
        wait_done(ok);
        tests++; if (dist_cm !== 9'd5) begin fails++; $display("FAIL rm1_dist got %0d want 5", dist_cm); end
        tests++; if (ch_idx !== 3'd1) begin fails++; $display("FAIL rm1_ch got %0d want 1", ch_idx); end
        tests++; if (near !== 2'b10) begin fails++; $display("FAIL rm1_near got %b want 10", near); end
    endtask

    task automatic test_saturation;
        int n;
        sat_start = 1'b1;
        @(negedge clk);
        sat_start = 1'b0;
        n = 0;
        while (sat_trig[0] === 1'b1 && n < 100) begin @(negedge clk); n++; end
        sat_echo[0] = 1'b1;
        repeat (1200) @(negedge clk);
        sat_echo[0] = 1'b0;
        n = 0;
        while (sat_done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        tests++; if (sat_done !== 1'b1) begin fails++; $display("FAIL sat_done got %b want 1", sat_done); end
        tests++; if (sat_dist !== 4'd15) begin fails++; $display("FAIL sat_dist got %0d want 15", sat_dist); end
        tests++; if (sat_tout !== 1'b0) begin fails++; $display("FAIL sat_tout got %b want 0", sat_tout); end
        tests++; if (sat_near !== 2'b01) begin fails++; $display("FAIL sat_near got %b want 01", sat_near); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_trig_width();
        test_partial_cm();
        test_no_echo();
        test_busy_reject();
        test_range();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
